// File: rtl/slave_port.sv
// Serial bus slave: shifts in a 16-bit address (+8-bit data on writes) and bridges to a local memory port.
// Latency: local strobe one cycle after the last address/data bit; read data serialised RD_LAT cycles after s_rd_en.
// Backpressure: master_valid low stalls the write side, master_ready low stalls the read side; sel low aborts.
module slave_port #(
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              sel,
    input  logic              mode,
    input  logic              wr_bus,
    input  logic              master_valid,
    output logic              slave_ready,
    output logic              rd_bus,
    output logic              slave_valid,
    input  logic              master_ready,
    output logic [ADDR_W-1:0] s_addr,
    output logic [7:0]        s_wr_data,
    output logic              s_wr_en,
    output logic              s_rd_en,
    input  logic [7:0]        s_rd_data
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ADDR    = 3'd1;
    localparam logic [2:0] WR_DATA = 3'd2;
    localparam logic [2:0] WRITE   = 3'd3;
    localparam logic [2:0] RD_REQ  = 3'd4;
    localparam logic [2:0] RD_WAIT = 3'd5;
    localparam logic [2:0] RD_DATA = 3'd6;
    localparam logic [2:0] DONE    = 3'd7;

    // RD_WAIT counts down from RD_LAT-2 so it lasts RD_LAT-1 cycles
    localparam logic [1:0] WAIT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

    logic [2:0]  state;
    logic [4:0]  cnt;
    logic        mode_q;
    logic [15:0] addr_sr;
    logic [7:0]  wd_sr;
    logic [7:0]  rd_sr;
    logic [1:0]  wait_cnt;
    logic [15:0] addr_nxt;
    logic [7:0]  wd_nxt;

    assign addr_nxt = {addr_sr[14:0], wr_bus};
    assign wd_nxt   = {wd_sr[6:0], wr_bus};

    // Handshake and strobe outputs are pure state decodes, so no input reaches them combinationally
    assign slave_ready = (state == ADDR) || (state == WR_DATA);
    assign slave_valid = (state == RD_DATA);
    assign rd_bus      = slave_valid & rd_sr[7];
    assign s_wr_en     = (state == WRITE);
    assign s_rd_en     = (state == RD_REQ);

    // Transaction FSM with its shift registers, bit counter and local address/data holding registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            mode_q    <= 1'b0;
            addr_sr   <= 16'd0;
            wd_sr     <= 8'd0;
            rd_sr     <= 8'd0;
            wait_cnt  <= 2'd0;
            s_addr    <= '0;
            s_wr_data <= 8'd0;
        end else if (state != IDLE && !sel) begin
            // Abort: drop everything in flight, fetched read data included
            state    <= IDLE;
            cnt      <= 5'd0;
            mode_q   <= 1'b0;
            addr_sr  <= 16'd0;
            wd_sr    <= 8'd0;
            rd_sr    <= 8'd0;
            wait_cnt <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel && master_valid) state <= ADDR;
                end
                ADDR: begin
                    if (master_valid) begin
                        addr_sr <= addr_nxt;
                        if (cnt == 5'd0) mode_q <= mode;
                        if (cnt == 5'd15) begin
                            cnt    <= 5'd0;
                            s_addr <= addr_nxt[ADDR_W-1:0];
                            state  <= mode_q ? WR_DATA : RD_REQ;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                WR_DATA: begin
                    if (master_valid) begin
                        wd_sr <= wd_nxt;
                        if (cnt == 5'd7) begin
                            cnt       <= 5'd0;
                            s_wr_data <= wd_nxt;
                            state     <= WRITE;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                WRITE: begin
                    state <= DONE;
                end
                RD_REQ: begin
                    if (RD_LAT == 1) begin
                        rd_sr <= s_rd_data;
                        state <= RD_DATA;
                    end else begin
                        wait_cnt <= WAIT_INIT;
                        state    <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        rd_sr <= s_rd_data;
                        state <= RD_DATA;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                RD_DATA: begin
                    if (master_ready) begin
                        rd_sr <= {rd_sr[6:0], 1'b0};
                        if (cnt == 5'd7) begin
                            cnt   <= 5'd0;
                            state <= DONE;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                DONE: begin
                    cnt     <= 5'd0;
                    mode_q  <= 1'b0;
                    addr_sr <= 16'd0;
                    wd_sr   <= 8'd0;
                    rd_sr   <= 8'd0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/slave_port.md
SLAVE_PORT -- requirements
Module: slave_port

Interface
REQ-001 Parameter ADDR_W, default 12, meaning: local address width taken from the low bits of the 16-bit bus address (1..16).
REQ-002 Parameter RD_LAT, default 1, meaning: fixed local-memory read latency in clk cycles (1..4).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 sel  input  1  decoder select; high while this slave owns the current transaction.
REQ-006 mode  input  1  transaction type from master; 1 = write, 0 = read.
REQ-007 wr_bus  input  1  serial address/write-data bit from master, MSB first.
REQ-008 master_valid  input  1  master drives a valid bit on wr_bus.
REQ-009 slave_ready  output  1  slave accepts a bit on wr_bus.
REQ-010 rd_bus  output  1  serial read-data bit to master, MSB first.
REQ-011 slave_valid  output  1  slave drives a valid bit on rd_bus.
REQ-012 master_ready  input  1  master accepts a bit on rd_bus.
REQ-013 s_addr  output  ADDR_W  local address, low ADDR_W bits of the received 16-bit address.
REQ-014 s_wr_data  output  8  local write data.
REQ-015 s_wr_en  output  1  one-cycle local write strobe.
REQ-016 s_rd_en  output  1  one-cycle local read strobe.
REQ-017 s_rd_data  input  8  local read data, valid RD_LAT cycles after s_rd_en.

Function
REQ-018 States SHALL be IDLE, ADDR, WR_DATA, WRITE, RD_REQ, RD_WAIT, RD_DATA, DONE.
REQ-019 Write-side bit transfer SHALL occur at a rising edge with master_valid & slave_ready both high; read-side transfer at a rising edge with slave_valid & master_ready both high.
REQ-020 IDLE -> ADDR when sel & master_valid; slave_ready SHALL be high in ADDR and WR_DATA only, low elsewhere.
REQ-021 mode SHALL be latched on the first accepted address bit and held for the whole transaction.
REQ-022 ADDR SHALL shift in exactly 16 bits MSB first via a 5-bit counter; after the 16th transfer: -> WR_DATA if latched mode = 1, else -> RD_REQ.
REQ-023 WR_DATA SHALL shift in exactly 8 bits MSB first; after the 8th transfer -> WRITE.
REQ-024 WRITE: s_wr_en = 1 for exactly one cycle with s_addr and s_wr_data stable; -> DONE.
REQ-025 RD_REQ: s_rd_en = 1 for exactly one cycle with s_addr stable; -> RD_WAIT.
REQ-026 RD_WAIT SHALL last RD_LAT-1 cycles (0 for RD_LAT = 1); s_rd_data SHALL be loaded into the 8-bit read shift register on the edge exactly RD_LAT cycles after s_rd_en, entering RD_DATA.
REQ-027 RD_DATA: slave_valid = 1, rd_bus = shift-register MSB; each transfer shifts left with 0 fill; after the 8th transfer -> DONE.
REQ-028 rd_bus SHALL be 0 whenever slave_valid = 0.
REQ-029 DONE SHALL clear the bit counter, latched mode, and both shift registers, then -> IDLE; s_addr and s_wr_data hold their last values.
REQ-030 Stalls: with master_valid = 0 (write side) or master_ready = 0 (read side), state, counter and shift registers SHALL hold indefinitely.
REQ-031 Abort: sel = 0 in any state other than IDLE SHALL force -> IDLE next edge; s_wr_en is not issued; counter, mode and shift registers cleared.
REQ-032 An abort in RD_WAIT or RD_DATA SHALL discard the fetched data; an already-issued s_rd_en is not retracted.
REQ-033 Back-to-back: a new transaction SHALL be accepted from IDLE on the cycle after DONE; no transaction is accepted while not in IDLE.
REQ-034 All outputs except rd_bus SHALL be registered or decoded from state only; no combinational path from any input to slave_ready or slave_valid.

Reset
REQ-035 On rstn low, asynchronously: state = IDLE, counter = 0, mode latch = 0, shift registers = 0, s_addr = 0, s_wr_data = 0, s_wr_en = 0, s_rd_en = 0, slave_ready = 0, slave_valid = 0, rd_bus = 0.
REQ-036 Reset asserted mid-transaction SHALL abandon it with no local strobe; after rstn high the block SHALL accept a fresh transaction from IDLE.

Verification
REQ-037 Write: sel = 1, mode = 1, address 0xA5C3, data 0x3C, continuous valid -> one s_wr_en pulse with s_addr = 0x5C3, s_wr_data = 0x3C, exactly 24 accepted bits.
REQ-038 Read, RD_LAT = 1 and RD_LAT = 3: address 0x0123, s_rd_data = 0x96 -> one s_rd_en with s_addr = 0x123; rd_bus serial 1,0,0,1,0,1,1,0 under slave_valid.
REQ-039 Stalls: random gaps in master_valid during address/write and in master_ready during read -> same results as REQ-037/038, no lost or duplicated bits.
REQ-040 Abort: sel dropped after 6 address bits, then after 3 write-data bits -> IDLE next cycle, no s_wr_en; next transaction completes correctly.
REQ-041 Reset: rstn pulsed low during RD_DATA bit 4 -> all outputs at reset values immediately; subsequent write 0x0001/0xFF produces s_wr_en with s_addr = 0x001, s_wr_data = 0xFF.
REQ-042 Back-to-back: write then read with no idle gap beyond DONE -> both complete, each strobe exactly once.
